branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter PC_WIDTH, default 32, sets the program-counter width.
REQ-002 Parameter ENTRIES, default 64, sets the table depth (power of 2, >=2); IDX=log2(ENTRIES).
REQ-003 Parameter CNT_INIT, default 2'b01, sets the counter value written on invalidate (weakly not-taken).
REQ-004 Parameter STAT_WIDTH, default 16, sets the statistics counter width.
REQ-005 The block SHALL use one clock, clk, with an asynchronous active-low reset, rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 lookup_en  input  1  fetch advancing (~stall_f).
REQ-009 pc_f  input  PC_WIDTH  fetch PC.
REQ-010 pred_taken  output  1  prediction for pc_f.
REQ-011 pred_next_pc  output  PC_WIDTH  predicted next fetch PC.
REQ-012 update_valid  input  1  a branch or jump resolved in execute.
REQ-013 update_pc, update_target  input  PC_WIDTH  resolved PC and resolved target.
REQ-014 update_taken, update_is_jump  input  1  resolved direction; unconditional jump.
REQ-015 update_pred_taken, update_pred_target  input  1, PC_WIDTH  prediction carried down the pipe.
REQ-016 mispredict  output  1  flush request.
REQ-017 redirect_pc  output  PC_WIDTH  correct PC on mispredict.
REQ-018 invalidate  input  1  pulse that starts a table clear.
REQ-019 busy  output  1  clear in progress.
REQ-020 stat_clr  input  1  synchronous statistics clear.
REQ-021 branch_count, mispredict_count  output  STAT_WIDTH  statistics counters.

Function
REQ-022 The table SHALL be direct-mapped with ENTRIES entries of {valid, tag, 2-bit counter, target}; index=pc[IDX+1:2]; tag=pc[PC_WIDTH-1:IDX+2].
REQ-023 Lookup SHALL be combinational from the current table contents: hit = lookup_en & ~busy & valid & tag match.
REQ-024 pred_taken SHALL equal hit & counter[1]; pred_next_pc SHALL be target when pred_taken, else pc_f+4 (modulo 2^PC_WIDTH).
REQ-025 mispredict SHALL equal update_valid & ((update_taken != update_pred_taken) | (update_taken & update_target != update_pred_target)), combinationally.
REQ-026 redirect_pc SHALL be update_target if update_taken, else update_pc+4.
REQ-027 An update SHALL write the table on the next rising edge; a same-cycle lookup of the same index SHALL see the old contents.
REQ-028 Update, tag hit, conditional branch: counter +1 if taken (saturate at 3), -1 if not taken (saturate at 0); target overwritten only when taken.
REQ-029 Update, tag hit, jump: counter=3 and target=update_target.
REQ-030 Update, miss (invalid or tag mismatch), taken: allocate/replace with valid=1, new tag, target, counter=3 if jump else 2.
REQ-031 Update, miss, not taken: no table change.
REQ-032 FSM states SHALL be IDLE and CLEAR; IDLE->CLEAR on invalidate, with the pointer set to 0.
REQ-033 In CLEAR, one entry per cycle SHALL be written valid=0 and counter=CNT_INIT; CLEAR->IDLE after entry ENTRIES-1 (ENTRIES cycles total).
REQ-034 busy SHALL be 1 exactly while in CLEAR.
REQ-035 Updates arriving during CLEAR SHALL be dropped from the table but still counted and still drive mispredict.
REQ-036 invalidate asserted during CLEAR SHALL restart the pointer at 0.
REQ-037 branch_count SHALL increment on each update_valid; mispredict_count SHALL increment on each mispredict; both saturate at all-ones.
REQ-038 stat_clr SHALL zero both statistics counters and take priority over a same-cycle increment.

Reset
REQ-039 rst low SHALL, asynchronously, clear all valid bits, set all counters to CNT_INIT, zero all targets and tags, set the FSM to IDLE (busy=0), and zero branch_count and mispredict_count.
REQ-040 rst asserted mid-CLEAR SHALL abort the clear immediately; after release the block is in IDLE with an empty table.

Verification (ENTRIES=64)
REQ-041 After reset, lookup pc_f=0x100 -> pred_taken=0, pred_next_pc=0x104, busy=0, both counts=0.
REQ-042 Update pc=0x100, taken, target=0x200, pred_taken=0 -> mispredict=1, redirect_pc=0x200; next cycle lookup 0x100 -> pred_taken=1, pred_next_pc=0x200.
REQ-043 Then two not-taken updates at 0x100 -> counter 2->1->0, the first with mispredict=1; lookup 0x100 -> pred_next_pc=0x104.
REQ-044 With 0x100 allocated taken, lookup 0x1100 (same index, different tag) -> miss, pred_next_pc=0x1104.
REQ-045 invalidate pulse -> busy=1 for 64 cycles with every lookup not-taken, and an update during busy is dropped; afterwards lookup 0x100 misses.
REQ-046 With STAT_WIDTH=4, 20 updates -> branch_count=15; stat_clr together with an update -> branch_count=0.

Source files
------------

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch predictor with a 2-bit saturating direction counter
//   and a stored target per entry, plus a sequential table-clear engine and
//   saturating branch / mispredict statistics.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   lookup_en, pc_f          fetch-side lookup (lookup_en = fetch advancing)
//   pred_taken, pred_next_pc combinational prediction for pc_f
//   update_*                 resolved branch/jump from execute, plus the
//                            prediction that travelled with it
//   mispredict, redirect_pc  combinational flush request and correct PC
//   invalidate, busy         start a table clear / clear in progress
//   stat_clr                 synchronous clear of the statistics counters
//   branch_count,
//   mispredict_count         saturating statistics counters
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int         PC_WIDTH   = 32,
    parameter int         ENTRIES    = 64,
    parameter logic [1:0] CNT_INIT   = 2'b01,
    parameter int         STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // fetch lookup
    input  logic                  lookup_en,
    input  logic [PC_WIDTH-1:0]   pc_f,
    output logic                  pred_taken,
    output logic [PC_WIDTH-1:0]   pred_next_pc,
    // execute update
    input  logic                  update_valid,
    input  logic [PC_WIDTH-1:0]   update_pc,
    input  logic [PC_WIDTH-1:0]   update_target,
    input  logic                  update_taken,
    input  logic                  update_is_jump,
    input  logic                  update_pred_taken,
    input  logic [PC_WIDTH-1:0]   update_pred_target,
    output logic                  mispredict,
    output logic [PC_WIDTH-1:0]   redirect_pc,
    // table clear
    input  logic                  invalidate,
    output logic                  busy,
    // statistics
    input  logic                  stat_clr,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    // -------------------------------------------------------------------------
    // Table storage (flops, so reset can clear every entry at once)
    // -------------------------------------------------------------------------
    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [1:0]          cnt_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];

    // -------------------------------------------------------------------------
    // Clear FSM
    // -------------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [IDX-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (invalidate) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            S_CLEAR: begin
                busy = 1'b1;
                // a fresh invalidate restarts the sweep from entry 0
                if (invalidate) begin
                    ptr_d = '0;
                end else if (ptr_q == IDX'(ENTRIES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    ptr_d = ptr_q + IDX'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Lookup (combinational, sees contents before any same-cycle update)
    // -------------------------------------------------------------------------
    logic [IDX-1:0]   idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;

    assign idx_f = pc_f[IDX+1:2];
    assign tag_f = pc_f[PC_WIDTH-1:IDX+2];
    assign hit_f = lookup_en & ~busy & valid_q[idx_f] & (tag_q[idx_f] == tag_f);

    assign pred_taken   = hit_f & cnt_q[idx_f][1];
    assign pred_next_pc = pred_taken ? target_q[idx_f] : pc_f + PC_WIDTH'(4);

    // -------------------------------------------------------------------------
    // Resolution
    // -------------------------------------------------------------------------
    assign mispredict  = update_valid &
                         ((update_taken != update_pred_taken) |
                          (update_taken & (update_target != update_pred_target)));
    assign redirect_pc = update_taken ? update_target : update_pc + PC_WIDTH'(4);

    // -------------------------------------------------------------------------
    // Update decode: compute the new contents of entry idx_u
    // -------------------------------------------------------------------------
    logic [IDX-1:0]      idx_u;
    logic [TAG_W-1:0]    tag_u;
    logic                hit_u;
    logic                upd_we;
    logic [TAG_W-1:0]    upd_tag;
    logic [1:0]          upd_cnt;
    logic [PC_WIDTH-1:0] upd_target;

    assign idx_u = update_pc[IDX+1:2];
    assign tag_u = update_pc[PC_WIDTH-1:IDX+2];
    assign hit_u = valid_q[idx_u] & (tag_q[idx_u] == tag_u);

    always_comb begin
        upd_we     = 1'b0;
        upd_tag    = tag_q[idx_u];
        upd_cnt    = cnt_q[idx_u];
        upd_target = target_q[idx_u];
        // updates during a clear are dropped from the table
        if (update_valid && !busy) begin
            if (hit_u) begin
                upd_we = 1'b1;
                if (update_is_jump) begin
                    upd_cnt    = 2'b11;
                    upd_target = update_target;
                end else if (update_taken) begin
                    upd_cnt    = (cnt_q[idx_u] == 2'b11) ? 2'b11 : cnt_q[idx_u] + 2'b01;
                    upd_target = update_target;
                end else begin
                    upd_cnt    = (cnt_q[idx_u] == 2'b00) ? 2'b00 : cnt_q[idx_u] - 2'b01;
                end
            end else if (update_taken) begin
                // allocate or replace; not-taken misses leave the table alone
                upd_we     = 1'b1;
                upd_tag    = tag_u;
                upd_cnt    = update_is_jump ? 2'b11 : 2'b10;
                upd_target = update_target;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Table write: clear sweep or a single update per cycle
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                cnt_q[i]    <= CNT_INIT;
                target_q[i] <= '0;
            end
        end else if (busy) begin
            valid_q[ptr_q] <= 1'b0;
            cnt_q[ptr_q]   <= CNT_INIT;
        end else if (upd_we) begin
            valid_q[idx_u]  <= 1'b1;
            tag_q[idx_u]    <= upd_tag;
            cnt_q[idx_u]    <= upd_cnt;
            target_q[idx_u] <= upd_target;
        end
    end

    // -------------------------------------------------------------------------
    // Statistics (saturating, clear wins over increment)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (stat_clr) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (update_valid && (branch_count != '1))
                branch_count <= branch_count + STAT_WIDTH'(1);
            if (mispredict && (mispredict_count != '1))
                mispredict_count <= mispredict_count + STAT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//   Directed scoreboard bench. Stimulus drives inputs just after a rising edge
//   and pushes the hand-computed expected outputs into a queue; the monitor
//   drains the queue on the following falling edge and compares.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int PW = 32;
    localparam int SW = 4;

    localparam int F_PT   = 0;
    localparam int F_NPC  = 1;
    localparam int F_MP   = 2;
    localparam int F_RPC  = 3;
    localparam int F_BUSY = 4;
    localparam int F_BC   = 5;
    localparam int F_MC   = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          lookup_en = 1'b0;
    logic [PW-1:0] pc_f = '0;
    logic          pred_taken;
    logic [PW-1:0] pred_next_pc;
    logic          update_valid = 1'b0;
    logic [PW-1:0] update_pc = '0;
    logic [PW-1:0] update_target = '0;
    logic          update_taken = 1'b0;
    logic          update_is_jump = 1'b0;
    logic          update_pred_taken = 1'b0;
    logic [PW-1:0] update_pred_target = '0;
    logic          mispredict;
    logic [PW-1:0] redirect_pc;
    logic          invalidate = 1'b0;
    logic          busy;
    logic          stat_clr = 1'b0;
    logic [SW-1:0] branch_count;
    logic [SW-1:0] mispredict_count;

    branch_predictor #(
        .PC_WIDTH(PW), .ENTRIES(64), .CNT_INIT(2'b01), .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .lookup_en(lookup_en), .pc_f(pc_f),
        .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_target(update_target), .update_taken(update_taken),
        .update_is_jump(update_is_jump), .update_pred_taken(update_pred_taken),
        .update_pred_target(update_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .invalidate(invalidate), .busy(busy),
        .stat_clr(stat_clr),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        int          f;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_v(input string nm, input int f, input logic [31:0] v);
        exp_t e;
        e.nm = nm; e.f = f; e.v = v;
        q.push_back(e);
    endtask

    task automatic exp_pred(input string nm, input logic pt, input logic [31:0] npc);
        expect_v({nm, ".pt"}, F_PT, {31'b0, pt});
        expect_v({nm, ".npc"}, F_NPC, npc);
    endtask

    task automatic exp_res(input string nm, input logic mp, input logic [31:0] rpc);
        expect_v({nm, ".mp"}, F_MP, {31'b0, mp});
        expect_v({nm, ".rpc"}, F_RPC, rpc);
    endtask

    task automatic exp_cnt(input string nm, input int bc, input int mc);
        expect_v({nm, ".bc"}, F_BC, 32'(bc));
        expect_v({nm, ".mc"}, F_MC, 32'(mc));
    endtask

    // monitor: outputs are valid for the whole cycle, so compare mid-cycle
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.f)
                F_PT:    act = {31'b0, pred_taken};
                F_NPC:   act = pred_next_pc;
                F_MP:    act = {31'b0, mispredict};
                F_RPC:   act = redirect_pc;
                F_BUSY:  act = {31'b0, busy};
                F_BC:    act = {28'b0, branch_count};
                default: act = {28'b0, mispredict_count};
            endcase
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got %h, expected %h", e.nm, act, e.v);
            end
        end
    end

    // advance one cycle and return inputs to a quiet default
    task automatic cyc();
        @(posedge clk);
        #1;
        lookup_en      = 1'b1;
        update_valid   = 1'b0;
        update_taken   = 1'b0;
        update_is_jump = 1'b0;
        invalidate     = 1'b0;
        stat_clr       = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic jmp,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        update_valid       = 1'b1;
        update_pc          = pc;
        update_taken       = tk;
        update_is_jump     = jmp;
        update_target      = tgt;
        update_pred_taken  = ptk;
        update_pred_target = ptgt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // reset state
        cyc(); pc_f = 32'h100;
        exp_pred("rst_lookup", 1'b0, 32'h104);
        expect_v("rst_busy", F_BUSY, 0);
        exp_cnt("rst", 0, 0);

        // first taken: allocate, same-cycle lookup still sees old contents
        cyc(); pc_f = 32'h100; upd(32'h100, 1, 0, 32'h200, 0, 0);
        exp_res("alloc", 1'b1, 32'h200);
        exp_pred("alloc_same_cyc", 1'b0, 32'h104);

        // now predicted taken; resolve not-taken (2->1)
        cyc(); pc_f = 32'h100; upd(32'h100, 0, 0, 32'h0, 1, 32'h200);
        exp_pred("hit_taken", 1'b1, 32'h200);
        exp_res("nt1", 1'b1, 32'h104);
        exp_cnt("after_alloc", 1, 1);

        // counter 1 -> 0
        cyc(); pc_f = 32'h100; upd(32'h100, 0, 0, 32'h0, 0, 32'h0);
        exp_pred("cnt1", 1'b0, 32'h104);
        exp_res("nt2", 1'b0, 32'h104);

        // counter 0; jump hit forces counter 3 and new target
        cyc(); pc_f = 32'h100; upd(32'h100, 1, 1, 32'h300, 0, 32'h0);
        exp_pred("cnt0", 1'b0, 32'h104);
        exp_res("jump", 1'b1, 32'h300);
        exp_cnt("mid", 3, 2);

        cyc(); pc_f = 32'h100;
        exp_pred("after_jump", 1'b1, 32'h300);

        // alias: same index, different tag misses; wrong-target taken update
        cyc(); pc_f = 32'h1100; upd(32'h100, 1, 0, 32'h400, 1, 32'h300);
        exp_pred("alias_miss", 1'b0, 32'h1104);
        exp_res("wrong_tgt", 1'b1, 32'h400);

        // correct prediction
        cyc(); pc_f = 32'h100; upd(32'h100, 1, 0, 32'h400, 1, 32'h400);
        exp_pred("new_tgt", 1'b1, 32'h400);
        exp_res("correct", 1'b0, 32'h400);

        // second entry at index 1
        cyc(); pc_f = 32'h100; upd(32'h204, 1, 0, 32'h800, 0, 32'h0);
        exp_res("alloc2", 1'b1, 32'h800);

        // not-taken miss leaves table untouched
        cyc(); pc_f = 32'h204; upd(32'h308, 0, 0, 32'h0, 0, 32'h0);
        exp_pred("hit2", 1'b1, 32'h800);
        exp_res("nt_miss", 1'b0, 32'h30C);
        exp_cnt("pre_nt_miss", 7, 5);

        cyc(); pc_f = 32'h308;
        exp_pred("no_alloc", 1'b0, 32'h30C);

        cyc(); lookup_en = 1'b0; pc_f = 32'h100;
        exp_pred("lookup_off", 1'b0, 32'h104);

        // invalidate: 64 busy cycles, lookups suppressed, update dropped
        cyc(); pc_f = 32'h100; invalidate = 1'b1;
        exp_pred("pre_clear", 1'b1, 32'h400);
        expect_v("pre_clear_busy", F_BUSY, 0);
        for (int i = 0; i < 64; i++) begin
            cyc(); pc_f = 32'h100;
            expect_v("clr_busy", F_BUSY, 1);
            exp_pred("clr_lookup", 1'b0, 32'h104);
            if (i == 5) begin
                upd(32'h500, 1, 0, 32'h900, 0, 32'h0);
                exp_res("clr_upd", 1'b1, 32'h900);
            end
        end
        cyc(); pc_f = 32'h100;
        expect_v("clr_done", F_BUSY, 0);
        exp_pred("cleared", 1'b0, 32'h104);
        exp_cnt("post_clear", 9, 6);
        cyc(); pc_f = 32'h500;
        exp_pred("dropped", 1'b0, 32'h504);
        cyc(); pc_f = 32'h204;
        exp_pred("cleared2", 1'b0, 32'h208);

        // statistics saturation and clear priority
        for (int i = 0; i < 20; i++) begin
            cyc(); upd(32'h600, 0, 0, 32'h0, 0, 32'h0);
        end
        cyc(); upd(32'h600, 1, 0, 32'h700, 0, 32'h0); stat_clr = 1'b1;
        exp_cnt("saturated", 15, 6);
        cyc();
        exp_cnt("stat_clr", 0, 0);

        // invalidate during clear restarts the sweep
        cyc(); invalidate = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(); expect_v("rs_busy_a", F_BUSY, 1);
        end
        cyc(); invalidate = 1'b1; expect_v("rs_again", F_BUSY, 1);
        for (int i = 0; i < 64; i++) begin
            cyc(); expect_v("rs_busy_b", F_BUSY, 1);
        end
        cyc(); expect_v("rs_done", F_BUSY, 0);

        // reset mid-clear aborts immediately and empties the table
        cyc(); upd(32'h100, 1, 0, 32'h200, 0, 32'h0);
        cyc(); pc_f = 32'h100;
        exp_pred("pre_rst", 1'b1, 32'h200);
        exp_cnt("pre_rst", 1, 1);
        cyc(); invalidate = 1'b1;
        cyc(); pc_f = 32'h100;
        expect_v("pre_rst_busy", F_BUSY, 1);
        cyc(); rst = 1'b0;
        expect_v("in_rst_busy", F_BUSY, 0);
        exp_cnt("in_rst", 0, 0);
        cyc(); rst = 1'b1; pc_f = 32'h100;
        expect_v("post_rst_busy", F_BUSY, 0);
        exp_pred("post_rst", 1'b0, 32'h104);
        cyc(); pc_f = 32'h100;
        expect_v("post_rst_idle", F_BUSY, 0);
        exp_cnt("post_rst", 0, 0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
